pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 172 +++++++++++++++++
 tb/tb_pipe_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined two's-complement adder/subtractor.
//
// The WIDTH-bit carry chain is cut into STAGES equal slices. Stage k adds
// slice k of the operands using the carry registered by stage k-1. Each stage
// register also carries the operand bits still to be processed and the
// sum bits already produced, so every bit of one result leaves together.
//
// Optional feature: define PIPE_ADDER_SAT_EN to clamp sum_o on signed
// overflow (0x7F..F for positive overflow, 0x80..0 for negative overflow).
// Without it sum_o is the wrapped modulo-2^WIDTH result. ovf_o and carry_o
// are reported the same way in both builds.
//
// Handshake (valid/ready, both ports):
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - The whole pipeline moves as one unit: advance = !out_valid || out_ready.
//     When advance is 0 every stage register (valid bits included) holds.
//   - in_ready equals advance, combinationally; in_valid seen while in_ready
//     is 0 is not captured and must be held by the producer.
//   - out_valid, once raised, stays high with sum_o/carry_o/ovf_o stable
//     until the consumer takes it with out_ready.
//   - Empty slots (in_valid low while advancing) travel as invalid stages.
//
// Parameter rules: WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0.
// STAGES = 1 degenerates to a single registered ripple adder.

module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;

    // Pipeline-wide enable shared by every stage register.
    logic advance;

    // Registered contents of each stage, indexed by stage number.
    logic             st_v [STAGES];
    logic             st_c [STAGES];
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];

    // Move everything forward unless a finished result is waiting unread.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Values presented to this stage's slice adder.
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;

        // Slice result and the partial sum with this slice merged in.
        logic [SLICE:0]   slice_sum;
        logic [WIDTH-1:0] s_next;

        // Stage register.
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_head
            // Subtract is A + ~B + 1: invert B here and force the carry-in,
            // so later stages never need to know the mode.
            assign v_in = in_valid;
            assign a_in = a_i;
            assign b_in = sub_i ? ~b_i : b_i;
            assign c_in = sub_i | carry_i;
            assign s_in = '0;
        end else begin : g_body
            assign v_in = st_v[k-1];
            assign a_in = st_a[k-1];
            assign b_in = st_b[k-1];
            assign c_in = st_c[k-1];
            assign s_in = st_s[k-1];
        end

        // One SLICE-bit ripple segment; the extra top bit is the carry out.
        assign slice_sum = {1'b0, a_in[k*SLICE +: SLICE]}
                         + {1'b0, b_in[k*SLICE +: SLICE]}
                         + {{SLICE{1'b0}}, c_in};

        // Drop this slice's sum bits into the partial result.
        always_comb begin
            s_next                   = s_in;
            s_next[k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        end

        // Stage register: valid always follows on advance; data only loads
        // for a real operation so empty slots leave the previous data alone.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= slice_sum[SLICE];
                    a_q <= a_in;
                    b_q <= b_in;
                    s_q <= s_next;
                end
            end
        end

        assign st_v[k] = v_q;
        assign st_c[k] = c_q;
        assign st_a[k] = a_q;
        assign st_b[k] = b_q;
        assign st_s[k] = s_q;
    end

    // Final stage views.
    logic             last_v;
    logic             last_c;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [WIDTH-1:0] last_s;
    logic             ovf;

    assign last_v = st_v[STAGES-1];
    assign last_c = st_c[STAGES-1];
    assign last_a = st_a[STAGES-1];
    assign last_b = st_b[STAGES-1];
    assign last_s = st_s[STAGES-1];

    // Only the operand sign bits matter once the sum is complete.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{last_a[MSB-1:0], last_b[MSB-1:0]};

    // Signed overflow: operands (B already inverted for subtract) agree in
    // sign and the sum's sign differs. All inputs are stage registers, so
    // the outputs stay stable while the pipeline is held.
    always_comb begin
        ovf   = (last_a[MSB] == last_b[MSB]) && (last_s[MSB] != last_a[MSB]);
        sum_o = last_s;
`ifdef PIPE_ADDER_SAT_EN
        if (ovf) begin
            // Negative operands overflowing clamp low, positive clamp high.
            sum_o = last_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    assign out_valid = last_v;
    assign carry_o   = last_c;
    assign ovf_o     = ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed self-checking bench for pipe_adder, WIDTH=16,
// STAGES=2. Expected results are hand-computed constants; the sat/wrap
// variants follow PIPE_ADDER_SAT_EN.

module tb_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 2;

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [15:0] S_7FFF_P1   = 16'h7FFF;  // 0x7FFF + 0x0001
    localparam logic [15:0] S_8000_M1   = 16'h8000;  // 0x8000 - 0x0001
    localparam logic [15:0] S_8000_P8   = 16'h8000;  // 0x8000 + 0x8000
    localparam logic [15:0] S_4000_P4   = 16'h7FFF;  // 0x4000 + 0x4000
`else
    localparam logic [15:0] S_7FFF_P1   = 16'h8000;
    localparam logic [15:0] S_8000_M1   = 16'h7FFF;
    localparam logic [15:0] S_8000_P8   = 16'h0000;
    localparam logic [15:0] S_4000_P4   = 16'h8000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             carry_i;
    logic             sub_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;
    logic             ovf_o;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .carry_i   (carry_i),
        .sub_i     (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_o     (sum_o),
        .carry_o   (carry_o),
        .ovf_o     (ovf_o)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q[$];   // {carry, ovf, sum}
    logic [33:0] in_q[$];    // {a, b, carry_i, sub_i}

    function automatic logic [17:0] res(input logic c, input logic o, input logic [15:0] s);
        return {c, o, s};
    endfunction

    function automatic logic [33:0] op(input logic [15:0] a, input logic [15:0] b,
                                       input logic c, input logic s);
        return {a, b, c, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [33:0] o);
        in_valid = 1'b1;
        {a_i, b_i, carry_i, sub_i} = o;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        a_i      = '0;
        b_i      = '0;
        carry_i  = 1'b0;
        sub_i    = 1'b0;
    endtask

    // One operation into an empty pipeline: accepted on the first edge,
    // not yet visible after one edge, visible with the result after two.
    task automatic run_one(input string tag, input logic [33:0] o, input logic [17:0] exp);
        @(negedge clk);
        drive(o);
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'({carry_o, ovf_o, sum_o}), 32'(exp));
    endtask

    // Streams everything in in_q, stalling the consumer for stall_len
    // cycles at the first result; checks order, hold and count.
    task automatic stream(input int n_ops, input int stall_len);
        int stall_left;
        bit stalled_once;
        int delivered;
        stall_left   = 0;
        stalled_once = 0;
        delivered    = 0;
        for (int cyc = 0; cyc < 60 && exp_q.size() != 0; cyc++) begin
            @(negedge clk);
            if (out_valid && !stalled_once) begin
                stalled_once = 1;
                stall_left   = stall_len;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (in_q.size() != 0) drive(in_q[0]);
            else idle_inputs();
            #1;
            if (!out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_valid", 32'(out_valid), 32'd1);
                if (exp_q.size() != 0)
                    check("stall_hold", 32'({carry_o, ovf_o, sum_o}), 32'(exp_q[0]));
            end
            if (in_valid && in_ready && in_q.size() != 0) void'(in_q.pop_front());
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    check("stream_out", 32'({carry_o, ovf_o, sum_o}), 32'(exp_q.pop_front()));
                end else begin
                    check("stream_extra", 32'(out_valid), 32'd0);
                end
                delivered++;
            end
        end
        check("stream_stalled", 32'(stalled_once), 32'd1);
        check("stream_count", 32'(delivered), 32'(n_ops));
        check("stream_pending", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        idle_inputs();
        @(negedge clk);
        #1;
        check("stream_no_dup", 32'(out_valid), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        idle_inputs();

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_carry", 32'(carry_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single operations.
        run_one("add_ffff_1",  op(16'hFFFF, 16'h0001, 1'b0, 1'b0), res(1'b1, 1'b0, 16'h0000));
        run_one("add_7fff_1",  op(16'h7FFF, 16'h0001, 1'b0, 1'b0), res(1'b0, 1'b1, S_7FFF_P1));
        run_one("sub_5_7",     op(16'h0005, 16'h0007, 1'b0, 1'b1), res(1'b0, 1'b0, 16'hFFFE));
        run_one("sub_8000_1",  op(16'h8000, 16'h0001, 1'b0, 1'b1), res(1'b1, 1'b1, S_8000_M1));
        run_one("add_cin",     op(16'h1234, 16'h4321, 1'b1, 1'b0), res(1'b0, 1'b0, 16'h5556));
        run_one("sub_cin_ign", op(16'h0010, 16'h0010, 1'b1, 1'b1), res(1'b1, 1'b0, 16'h0000));
        run_one("add_slice_c", op(16'h00FF, 16'h0001, 1'b0, 1'b0), res(1'b0, 1'b0, 16'h0100));
        run_one("add_neg_ovf", op(16'h8000, 16'h8000, 1'b0, 1'b0), res(1'b1, 1'b1, S_8000_P8));

        // Four back-to-back operations with a 3-cycle consumer stall.
        in_q.push_back(op(16'h0001, 16'h0002, 1'b0, 1'b0));
        exp_q.push_back(res(1'b0, 1'b0, 16'h0003));
        in_q.push_back(op(16'h00FF, 16'h0101, 1'b0, 1'b0));
        exp_q.push_back(res(1'b0, 1'b0, 16'h0200));
        in_q.push_back(op(16'hFFFF, 16'h0001, 1'b0, 1'b1));
        exp_q.push_back(res(1'b1, 1'b0, 16'hFFFE));
        in_q.push_back(op(16'h4000, 16'h4000, 1'b0, 1'b0));
        exp_q.push_back(res(1'b0, 1'b1, S_4000_P4));
        stream(4, 3);

        // Reset with two operations in flight.
        @(negedge clk);
        drive(op(16'h7FFF, 16'h0001, 1'b0, 1'b0));
        @(negedge clk);
        drive(op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0));
        @(negedge clk);
        idle_inputs();
        #1;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum_o), 32'd0);
        check("midrst_carry", 32'(carry_o), 32'd0);
        check("midrst_ovf", 32'(ovf_o), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("no_stale", 32'(out_valid), 32'd0);
        end
        run_one("after_rst", op(16'h1234, 16'h4321, 1'b1, 1'b0), res(1'b0, 1'b0, 16'h5556));

        // ---------------- final report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case anything above stops making progress.
    initial begin
        #20000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
